// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter and refresh scheduler for the
// capture-to-VGA frame buffer path.
//
// The block owns the single SDRAM command/address/data bus. It hands the bus
// in turn to the init, auto-refresh, write and read sub-modules. It also
// raises the periodic refresh request.
//
// Parameters:
//   REF_PERIOD  clocks between refresh requests (16..2047)
//   TIMEOUT     maximum clocks in AREF/WRITE/READ before a forced return
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   init_done                       power-up sequence finished (level)
//   init_cmd/init_addr              init sub-module bus
//   ref_cmd/ref_addr/ref_end        refresh sub-module bus + done pulse
//   wr_req/wr_cmd/wr_addr/wr_dq/wr_end  write sub-module bus + burst-done
//   rd_req/rd_cmd/rd_addr/rd_end    read sub-module bus + burst-done
//   ref_en/wr_en/rd_en              one-cycle grant pulses
//   state                           one-hot state broadcast
//   sdram_cmd/addr/dq_out/dq_oe     registered pin outputs
//   ref_req                         refresh pending (sticky)
//   ref_overrun, timeout_err        sticky error flags
//
// Build option:
//   SDRAM_ARBIT_RR_EN  write/read ties alternate on a last-grant bit.
//                      When it is undefined, write always beats read.
//
// state | meaning
// INIT  | waiting for the power-up sequence
// ARBIT | bus idle (NOP), picks the next owner
// AREF  | auto-refresh sub-module owns the bus
// WRITE | write sub-module owns the bus, DQ driven
// READ  | read sub-module owns the bus

module sdram_arbit #(
    parameter logic [10:0] REF_PERIOD = 11'd780,
    parameter logic [7:0]  TIMEOUT    = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    input  logic [3:0]  ref_cmd,
    input  logic [12:0] ref_addr,
    input  logic        ref_end,
    input  logic        wr_req,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [15:0] wr_dq,
    input  logic        wr_end,
    input  logic        rd_req,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic        rd_end,
    output logic        ref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic [4:0]  state,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        ref_req,
    output logic        ref_overrun,
    output logic        timeout_err
);

    typedef enum logic [4:0] {
        S_INIT  = 5'b0_0001,
        S_ARBIT = 5'b0_0010,
        S_AREF  = 5'b0_0100,
        S_WRITE = 5'b0_1000,
        S_READ  = 5'b1_0000
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    state_t      r_state;
    state_t      w_next_state;
    logic [10:0] r_ref_cnt;
    logic [7:0]  r_to_cnt;
    logic        r_ref_req;
    logic        r_ref_overrun;
    logic        r_timeout_err;
    logic        r_ref_en;
    logic        r_wr_en;
    logic        r_rd_en;
    logic [3:0]  r_cmd;
    logic [12:0] r_addr;
    logic [15:0] r_dq;
    logic        r_dq_oe;

    logic        w_wrap;
    logic        w_to_hit;
    logic        w_wr_wins;
    logic        w_grant_ref;
    logic        w_grant_wr;
    logic        w_grant_rd;
    logic        w_expire;

    assign w_wrap   = init_done && (r_ref_cnt == REF_PERIOD - 11'd1);
    assign w_to_hit = (r_to_cnt == TIMEOUT - 8'd1);

`ifdef SDRAM_ARBIT_RR_EN
    // Remembers who won the last write/read grant. It resets to "read" so
    // that write wins the first tie.
    logic r_last_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_wr <= 1'b0;
        else if (w_grant_wr)
            r_last_wr <= 1'b1;
        else if (w_grant_rd)
            r_last_wr <= 1'b0;
    end

    assign w_wr_wins = ~r_last_wr;
`else
    assign w_wr_wins = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_INIT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_ref  = 1'b0;
        w_grant_wr   = 1'b0;
        w_grant_rd   = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_INIT: begin
                if (init_done)
                    w_next_state = S_ARBIT;
            end
            S_ARBIT: begin
                if (init_done) begin
                    if (r_ref_req) begin
                        w_grant_ref  = 1'b1;
                        w_next_state = S_AREF;
                    end else if (wr_req && (!rd_req || w_wr_wins)) begin
                        w_grant_wr   = 1'b1;
                        w_next_state = S_WRITE;
                    end else if (rd_req) begin
                        w_grant_rd   = 1'b1;
                        w_next_state = S_READ;
                    end
                end
            end
            S_AREF: begin
                if (ref_end) begin
                    w_next_state = S_ARBIT;
                end else if (w_to_hit) begin
                    w_next_state = S_ARBIT;
                    w_expire     = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_end) begin
                    w_next_state = S_ARBIT;
                end else if (w_to_hit) begin
                    w_next_state = S_ARBIT;
                    w_expire     = 1'b1;
                end
            end
            S_READ: begin
                if (rd_end) begin
                    w_next_state = S_ARBIT;
                end else if (w_to_hit) begin
                    w_next_state = S_ARBIT;
                    w_expire     = 1'b1;
                end
            end
            default: w_next_state = S_INIT;
        endcase
    end

    // Refresh timer and pending/overrun flags. A wrap that lands on the
    // same edge as the refresh grant re-arms the request, because a new
    // refresh is owed; this is not counted as an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt     <= 11'd0;
            r_ref_req     <= 1'b0;
            r_ref_overrun <= 1'b0;
        end else begin
            if (!init_done || w_wrap)
                r_ref_cnt <= 11'd0;
            else
                r_ref_cnt <= r_ref_cnt + 11'd1;

            if (w_wrap) begin
                r_ref_req <= 1'b1;
                if (r_ref_req && !w_grant_ref)
                    r_ref_overrun <= 1'b1;
            end else if (w_grant_ref) begin
                r_ref_req <= 1'b0;
            end
        end
    end

    // Dwell counter: zero outside the busy states and on every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != S_INIT && r_state != S_ARBIT && w_next_state == r_state)
                r_to_cnt <= r_to_cnt + 8'd1;
            else
                r_to_cnt <= 8'd0;
            if (w_expire)
                r_timeout_err <= 1'b1;
        end
    end

    // Pins are loaded according to the next state. The pin contents then
    // change on the same edge as the state bus, so command, address and
    // data each carry one clock of latency and DQ is enabled exactly while
    // the state reads WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_en <= 1'b0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_cmd    <= CMD_NOP;
            r_addr   <= 13'd0;
            r_dq     <= 16'd0;
            r_dq_oe  <= 1'b0;
        end else begin
            r_ref_en <= w_grant_ref;
            r_wr_en  <= w_grant_wr;
            r_rd_en  <= w_grant_rd;
            r_dq     <= 16'd0;
            r_dq_oe  <= 1'b0;
            case (w_next_state)
                S_INIT: begin
                    r_cmd  <= init_cmd;
                    r_addr <= init_addr;
                end
                S_AREF: begin
                    r_cmd  <= ref_cmd;
                    r_addr <= ref_addr;
                end
                S_WRITE: begin
                    r_cmd   <= wr_cmd;
                    r_addr  <= wr_addr;
                    r_dq    <= wr_dq;
                    r_dq_oe <= 1'b1;
                end
                S_READ: begin
                    r_cmd  <= rd_cmd;
                    r_addr <= rd_addr;
                end
                default: begin
                    r_cmd  <= CMD_NOP;
                    r_addr <= 13'd0;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign ref_en       = r_ref_en;
    assign wr_en        = r_wr_en;
    assign rd_en        = r_rd_en;
    assign sdram_cmd    = r_cmd;
    assign sdram_addr   = r_addr;
    assign sdram_dq_out = r_dq;
    assign sdram_dq_oe  = r_dq_oe;
    assign ref_req      = r_ref_req;
    assign ref_overrun  = r_ref_overrun;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_sdram_arbit.sv
module tb_sdram_arbit;

    localparam int P   = 100;
    localparam int TO  = 64;
    localparam logic [4:0] ST_INIT  = 5'b00001;
    localparam logic [4:0] ST_ARBIT = 5'b00010;
    localparam logic [4:0] ST_AREF  = 5'b00100;
    localparam logic [4:0] ST_WRITE = 5'b01000;
    localparam logic [4:0] ST_READ  = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
    logic [12:0] init_addr, ref_addr, wr_addr, rd_addr;
    logic [15:0] wr_dq;
    logic        ref_end, wr_req, wr_end, rd_req, rd_end;

    logic        ref_en, wr_en, rd_en, sdram_dq_oe, ref_req, ref_overrun, timeout_err;
    logic [4:0]  state;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;

    logic        ref_en_2, wr_en_2, rd_en_2, sdram_dq_oe_2, ref_req_2, ref_overrun_2, timeout_err_2;
    logic [4:0]  state_2;
    logic [3:0]  sdram_cmd_2;
    logic [12:0] sdram_addr_2;
    logic [15:0] sdram_dq_out_2;

    int total = 0;
    int bad   = 0;
    int n;
    int got;
    int cnt;

    always #5 clk = ~clk;

    sdram_arbit #(.REF_PERIOD(11'd100), .TIMEOUT(8'd64)) u_dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_end(ref_end),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_dq(wr_dq), .wr_end(wr_end),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_end(rd_end),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .state(state),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out),
        .sdram_dq_oe(sdram_dq_oe), .ref_req(ref_req), .ref_overrun(ref_overrun),
        .timeout_err(timeout_err)
    );

    sdram_arbit #(.REF_PERIOD(11'd100), .TIMEOUT(8'd255)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_end(ref_end),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_dq(wr_dq), .wr_end(wr_end),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_end(rd_end),
        .ref_en(ref_en_2), .wr_en(wr_en_2), .rd_en(rd_en_2), .state(state_2),
        .sdram_cmd(sdram_cmd_2), .sdram_addr(sdram_addr_2), .sdram_dq_out(sdram_dq_out_2),
        .sdram_dq_oe(sdram_dq_oe_2), .ref_req(ref_req_2), .ref_overrun(ref_overrun_2),
        .timeout_err(timeout_err_2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        init_done = 1'b0;
        init_cmd = 4'b0111; init_addr = '0;
        ref_cmd = 4'b0111;  ref_addr = '0;  ref_end = 1'b0;
        wr_req = 1'b0; wr_cmd = 4'b0111; wr_addr = '0; wr_dq = '0; wr_end = 1'b0;
        rd_req = 1'b0; rd_cmd = 4'b0111; rd_addr = '0; rd_end = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct packed {
        logic        id, wq, rq, we, re;
        logic [3:0]  c;
        logic [12:0] a;
        logic [15:0] d;
        logic [4:0]  e_state;
        logic [2:0]  e_en;
        logic [3:0]  e_cmd;
        logic [12:0] e_addr;
        logic        e_oe;
        logic [15:0] e_dq;
    } vec_t;

    vec_t tbl [12];

    // ---------------- behavioural reference model ----------------
    int   m_ph, m_run, m_dwell;
    bit   m_owed, m_ovr, m_toe, m_lastwr;
    logic [4:0]  x_state;
    logic [2:0]  x_en;
    logic [3:0]  x_cmd;
    logic [12:0] x_addr;
    logic        x_oe;
    logic [15:0] x_dq;

    task automatic model_reset();
        m_ph = 0; m_run = 0; m_dwell = 0;
        m_owed = 0; m_ovr = 0; m_toe = 0; m_lastwr = 0;
        x_state = ST_INIT; x_en = 3'b000; x_cmd = 4'b0111;
        x_addr = '0; x_oe = 1'b0; x_dq = '0;
    endtask

    // phase numbers: 0 init, 1 idle, 2 refresh, 3 write, 4 read
    task automatic model_step();
        int  nph, g;
        bit  wrap, endp;
        wrap = init_done && (m_run == P - 1);
        nph  = m_ph;
        g    = 0;
        if (m_ph == 0) begin
            if (init_done) nph = 1;
        end else if (m_ph == 1) begin
            if (init_done) begin
                if (m_owed) g = 2;
                else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
                    g = m_lastwr ? 4 : 3;
`else
                    g = 3;
`endif
                end else if (wr_req) g = 3;
                else if (rd_req) g = 4;
                if (g != 0) nph = g;
            end
        end else begin
            endp = (m_ph == 2) ? ref_end : (m_ph == 3) ? wr_end : rd_end;
            if (endp) nph = 1;
            else if (m_dwell == TO - 1) begin
                nph = 1;
                m_toe = 1;
            end
        end
        if (g == 3) m_lastwr = 1;
        else if (g == 4) m_lastwr = 0;
        if (wrap) begin
            if (m_owed && g != 2) m_ovr = 1;
            m_owed = 1;
        end else if (g == 2) begin
            m_owed = 0;
        end
        if (g != 0) m_dwell = 0;
        else if (m_ph >= 2 && nph == m_ph) m_dwell = m_dwell + 1;
        else m_dwell = 0;
        m_run = init_done ? ((m_run + 1) % P) : 0;
        m_ph = nph;
        x_state = 5'b00001 << nph;
        x_en = {g == 2, g == 3, g == 4};
        x_oe = 1'b0;
        x_dq = '0;
        case (nph)
            0: begin x_cmd = init_cmd; x_addr = init_addr; end
            2: begin x_cmd = ref_cmd;  x_addr = ref_addr;  end
            3: begin x_cmd = wr_cmd;   x_addr = wr_addr; x_oe = 1'b1; x_dq = wr_dq; end
            4: begin x_cmd = rd_cmd;   x_addr = rd_addr;  end
            default: begin x_cmd = 4'b0111; x_addr = '0; end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pat [4];
        int start;
        logic [63:0] act_v, exp_v;
`ifdef SDRAM_ARBIT_RR_EN
        exp_pat = '{1, 2, 1, 2};
`else
        exp_pat = '{1, 1, 1, 1};
`endif
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 4'b0010, 13'h400,  16'h0000, ST_INIT,  3'b000, 4'b0010, 13'h400, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0001, 13'h000,  16'h0000, ST_ARBIT, 3'b000, 4'b0111, 13'h000, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0111, 13'h100,  16'hA5A5, ST_WRITE, 3'b010, 4'b0111, 13'h102, 1'b1, 16'hA5A5};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 4'b0100, 13'h010,  16'h1234, ST_WRITE, 3'b000, 4'b0100, 13'h012, 1'b1, 16'h1234};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 4'b0111, 13'h020,  16'h5678, ST_ARBIT, 3'b000, 4'b0111, 13'h000, 1'b0, 16'h0000};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 4'b0100, 13'h030,  16'hFFFF, ST_READ,  3'b001, 4'b0101, 13'h033, 1'b0, 16'h0000};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b1, 4'b0100, 13'h040,  16'hFFFF, ST_ARBIT, 3'b000, 4'b0111, 13'h000, 1'b0, 16'h0000};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 4'b0110, 13'h050,  16'hBEEF, ST_WRITE, 3'b010, 4'b0110, 13'h052, 1'b1, 16'hBEEF};
        tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 4'b0110, 13'h050,  16'hBEEF, ST_ARBIT, 3'b000, 4'b0111, 13'h000, 1'b0, 16'h0000};
        tbl[9]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 4'b0111, 13'h060,  16'h0F0F, ST_READ,  3'b001, 4'b0110, 13'h063, 1'b0, 16'h0000};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 4'b0111, 13'h060,  16'h0000, ST_ARBIT, 3'b000, 4'b0111, 13'h000, 1'b0, 16'h0000};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 4'b0000, 13'h1FFF, 16'hFFFF, ST_ARBIT, 3'b000, 4'b0111, 13'h000, 1'b0, 16'h0000};

        // reset values
        clr_inputs();
        repeat (2) @(negedge clk);
        chk("rst_state", state, ST_INIT);
        chk("rst_cmd", sdram_cmd, 4'b0111);
        chk("rst_addr", sdram_addr, 0);
        chk("rst_dq", {sdram_dq_oe, sdram_dq_out}, 0);
        chk("rst_en", {ref_en, wr_en, rd_en}, 0);
        chk("rst_flags", {ref_req, ref_overrun, timeout_err}, 0);

        // table vectors
        do_reset();
        for (int i = 0; i < 12; i++) begin
            init_done = tbl[i].id;
            wr_req = tbl[i].wq;  rd_req = tbl[i].rq;
            wr_end = tbl[i].we;  rd_end = tbl[i].re;  ref_end = 1'b0;
            init_cmd = tbl[i].c;            init_addr = tbl[i].a;
            ref_cmd  = tbl[i].c ^ 4'b0011;  ref_addr  = tbl[i].a + 13'd1;
            wr_cmd   = tbl[i].c;            wr_addr   = tbl[i].a + 13'd2;
            rd_cmd   = tbl[i].c ^ 4'b0001;  rd_addr   = tbl[i].a + 13'd3;
            wr_dq    = tbl[i].d;
            tick();
            chk($sformatf("vec%0d", i),
                {state, ref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_dq_oe, sdram_dq_out},
                {tbl[i].e_state, tbl[i].e_en, tbl[i].e_cmd, tbl[i].e_addr, tbl[i].e_oe, tbl[i].e_dq});
        end

        // refresh request timing after init
        do_reset();
        repeat (9) tick();
        chk("init_hold", {state, ref_req}, {ST_INIT, 1'b0});
        init_done = 1'b1;
        tick();
        chk("init_exit", state, ST_ARBIT);
        n = 1;
        while (!ref_req && n < 200) begin tick(); n++; end
        chk("ref_req_delay", n, 100);
        chk("ref_wait_arbit", {state, ref_en}, {ST_ARBIT, 1'b0});
        ref_cmd = 4'b0001; ref_addr = 13'h400;
        tick();
        chk("ref_grant", {state, ref_en, ref_req}, {ST_AREF, 1'b1, 1'b0});
        chk("ref_pins", {sdram_cmd, sdram_addr}, {4'b0001, 13'h400});
        tick();
        chk("ref_en_width", {state, ref_en}, {ST_AREF, 1'b0});
        ref_end = 1'b1;
        tick();
        ref_end = 1'b0;
        chk("ref_done", {state, sdram_cmd}, {ST_ARBIT, 4'b0111});

        // refresh pending during a write burst: no preemption
        do_reset();
        init_done = 1'b1;
        repeat (60) tick();
        wr_req = 1'b1; wr_cmd = 4'b0100; wr_dq = 16'h5A5A;
        tick();
        chk("np_grant", {state, wr_en}, {ST_WRITE, 1'b1});
        n = 0;
        while (!ref_req && n < 100) begin tick(); n++; end
        chk("np_req_seen", ref_req, 1'b1);
        repeat (3) tick();
        chk("np_still_write", {state, ref_en, sdram_cmd, sdram_dq_oe}, {ST_WRITE, 1'b0, 4'b0100, 1'b1});
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        chk("np_end", {state, ref_req, wr_en, sdram_dq_oe}, {ST_ARBIT, 1'b1, 1'b0, 1'b0});
        tick();
        chk("np_aref", {state, ref_en, ref_req, wr_en}, {ST_AREF, 1'b1, 1'b0, 1'b0});

        // write/read tie over four grants
        do_reset();
        init_done = 1'b1;
        tick();
        wr_req = 1'b1; rd_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            got = 0;
            while (n < 20) begin
                tick(); n++;
                if (wr_en || rd_en) break;
            end
            got = wr_en ? 1 : (rd_en ? 2 : 0);
            chk($sformatf("tie_grant%0d", g), got, exp_pat[g]);
            wr_end = 1'b1; rd_end = 1'b1;
            tick();
            wr_end = 1'b0; rd_end = 1'b0;
        end

        // read burst without end pulse: timeout
        do_reset();
        init_done = 1'b1;
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("to_start", {state, timeout_err}, {ST_READ, 1'b0});
        n = 0;
        while (state == ST_READ && n < 100) begin tick(); n++; end
        chk("to_cycles", n, 64);
        chk("to_exit", {state, timeout_err}, {ST_ARBIT, 1'b1});
        repeat (5) tick();
        chk("to_sticky", timeout_err, 1'b1);

        // long write stall on the TIMEOUT=255 instance: overrun
        do_reset();
        init_done = 1'b1;
        wr_req = 1'b1;
        tick();
        repeat (209) tick();
        chk("ovr_stall", {state_2, ref_req_2, ref_overrun_2}, {ST_WRITE, 1'b1, 1'b1});
        wr_req = 1'b0; wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            ref_end = (state_2 == ST_AREF);
            tick();
            if (ref_en_2) cnt++;
        end
        ref_end = 1'b0;
        chk("ovr_single_aref", cnt, 1);
        chk("ovr_sticky", {ref_overrun_2, ref_req_2}, {1'b1, 1'b0});

        // asynchronous reset in the middle of a burst
        wr_req = 1'b1; wr_cmd = 4'b0100; wr_dq = 16'hCAFE; wr_addr = 13'h0AA;
        tick();
        chk("arst_pre", {state_2, sdram_dq_oe_2}, {ST_WRITE, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", {state_2, sdram_cmd_2, sdram_addr_2}, {ST_INIT, 4'b0111, 13'h000});
        chk("arst_dq", {sdram_dq_oe_2, sdram_dq_out_2, wr_en_2}, 0);
        chk("arst_flags", {ref_overrun_2, ref_req_2, timeout_err, ref_overrun}, 0);
        @(negedge clk);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        start = $urandom_range(20, 1);
        for (int k = 0; k < 3000; k++) begin
            act_v = {state, ref_en, wr_en, rd_en, sdram_cmd, sdram_addr, sdram_dq_oe,
                     sdram_dq_out, ref_req, ref_overrun, timeout_err};
            exp_v = {x_state, x_en, x_cmd, x_addr, x_oe, x_dq, m_owed, m_ovr, m_toe};
            chk($sformatf("rand%0d", k), act_v, exp_v);
            init_done = (k >= start);
            wr_req  = 1'($urandom_range(1, 0));
            rd_req  = 1'($urandom_range(1, 0));
            ref_end = ($urandom_range(19, 0) == 0);
            wr_end  = ($urandom_range(19, 0) == 0);
            rd_end  = ($urandom_range(19, 0) == 0);
            init_cmd = 4'($urandom); init_addr = 13'($urandom);
            ref_cmd  = 4'($urandom); ref_addr  = 13'($urandom);
            wr_cmd   = 4'($urandom); wr_addr   = 13'($urandom);
            rd_cmd   = 4'($urandom); rd_addr   = 13'($urandom);
            wr_dq    = 16'($urandom);
            model_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
